// File: rtl/vga_fb_scanout_pkg.sv
// Shared timing defaults, total-count helpers and RGB444 packing for vga_fb_scanout.
// The optional test-grid types are used only when VGA_FB_SCANOUT_PATTERN_EN is defined.
package vga_fb_scanout_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel control that travels alongside the RAM read
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic in_fb;
    logic show_fb;
    logic fs;
  } ctrl_t;

  typedef struct packed {
    logic    en;
    rgb444_t rgb;
  } pat_t;

  function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic logic [11:0] rgb444_pack(input rgb444_t c);
    return {c.r, c.g, c.b};
  endfunction

  function automatic rgb444_t rgb444_unpack(input logic [11:0] p);
    rgb444_t c;
    c.r = p[11:8];
    c.g = p[7:4];
    c.b = p[3:0];
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_scanout_fb_dpram.sv
// Simple dual-port framebuffer RAM: one write port, one read port, read-first,
// with RD_LAT registered read stages so the array maps onto block RAM.
module fb_dpram #(
  parameter int AW     = 14,
  parameter int DW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] q_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage 0 samples the array before this cycle's write lands, giving read-first
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          q_pipe[gi] <= mem[rd_addr];
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          q_pipe[gi] <= q_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign rd_data = q_pipe[RD_LAT-1];

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA timing generator with scaled framebuffer scanout; outputs lag the counters by RD_LAT+1.
// Define VGA_FB_SCANOUT_PATTERN_EN to add the pattern_sel test-grid overlay.
module vga_fb_scanout
  import vga_fb_scanout_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int FB_XBITS    = 7,
  parameter int FB_YBITS    = 7,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_W       = 12,
  parameter int RD_LAT      = 2,
  parameter logic [PIX_W-1:0] BG = PIX_W'(12'h000)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [FB_XBITS+FB_YBITS-1:0] wr_addr,
  input  logic [PIX_W-1:0]             wr_data,
  input  logic                         fb_enable,
`ifdef VGA_FB_SCANOUT_PATTERN_EN
  input  logic                         pattern_sel,
`endif
  output logic                         hsync,
  output logic                         vsync,
  output logic                         de,
  output logic [3:0]                   r,
  output logic [3:0]                   g,
  output logic [3:0]                   b,
  output logic                         frame_start
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int AW      = FB_XBITS + FB_YBITS;
  localparam logic HS_ACT = HSYNC_POL[0];
  localparam logic VS_ACT = VSYNC_POL[0];

  logic [HCW-1:0] hpos_reg;
  logic [VCW-1:0] vpos_reg;
  logic           fb_en_lat_reg;

  logic [31:0]    h_wide;
  logic [31:0]    v_wide;
  logic [31:0]    fb_x;
  logic [31:0]    fb_y;
  logic           at_origin;
  logic           show_fb_now;
  ctrl_t          ctrl_now;
  ctrl_t          ctrl_pipe [RD_LAT];
  ctrl_t          ctrl_last;
  logic [AW-1:0]  rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [PIX_W-1:0] pix_next;
  rgb444_t        color_next;

  // ---------------- position counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_reg <= '0;
      vpos_reg <= '0;
    end else if (hpos_reg == HCW'(H_TOTAL - 1)) begin
      hpos_reg <= '0;
      if (vpos_reg == VCW'(V_TOTAL - 1)) vpos_reg <= '0;
      else vpos_reg <= vpos_reg + 1'b1;
    end else begin
      hpos_reg <= hpos_reg + 1'b1;
    end
  end

  assign h_wide    = 32'(hpos_reg);
  assign v_wide    = 32'(vpos_reg);
  assign fb_x      = h_wide >> SCALE_SHIFT;
  assign fb_y      = v_wide >> SCALE_SHIFT;
  assign at_origin = (hpos_reg == '0) && (vpos_reg == '0);
  assign rd_addr   = {fb_y[FB_YBITS-1:0], fb_x[FB_XBITS-1:0]};

  // The origin pixel uses the live enable so the whole frame sees one value
  assign show_fb_now = at_origin ? fb_enable : fb_en_lat_reg;

  always_ff @(posedge clk) begin
    if (reset) fb_en_lat_reg <= 1'b0;
    else if (at_origin) fb_en_lat_reg <= fb_enable;
  end

  always_comb begin
    ctrl_now         = '0;
    ctrl_now.de      = (h_wide < H_VISIBLE) && (v_wide < V_VISIBLE);
    ctrl_now.in_fb   = ctrl_now.de && (fb_x < (32'd1 << FB_XBITS)) && (fb_y < (32'd1 << FB_YBITS));
    ctrl_now.hs      = (h_wide >= H_VISIBLE + H_FP) && (h_wide < H_VISIBLE + H_FP + H_SYNC);
    ctrl_now.vs      = (v_wide >= V_VISIBLE + V_FP) && (v_wide < V_VISIBLE + V_FP + V_SYNC);
    ctrl_now.show_fb = show_fb_now;
    ctrl_now.fs      = at_origin;
  end

  // ---------------- framebuffer ----------------
  fb_dpram #(
    .AW     (AW),
    .DW     (PIX_W),
    .RD_LAT (RD_LAT)
  ) u_fb (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- control delay line matching the RAM ----------------
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_ctrl
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) ctrl_pipe[gi] <= '0;
          else ctrl_pipe[gi] <= ctrl_now;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) ctrl_pipe[gi] <= '0;
          else ctrl_pipe[gi] <= ctrl_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign ctrl_last = ctrl_pipe[RD_LAT-1];

`ifdef VGA_FB_SCANOUT_PATTERN_EN
  logic    pat_lat_reg;
  pat_t    pat_now;
  pat_t    pat_pipe [RD_LAT];
  pat_t    pat_last;

  always_ff @(posedge clk) begin
    if (reset) pat_lat_reg <= 1'b0;
    else if (at_origin) pat_lat_reg <= pattern_sel;
  end

  always_comb begin
    pat_now       = '0;
    pat_now.en    = at_origin ? pattern_sel : pat_lat_reg;
    pat_now.rgb.r = {4{(hpos_reg[2:0] == 3'd0) || (vpos_reg[2:0] == 3'd0)}};
    pat_now.rgb.g = {4{vpos_reg[4]}};
    pat_now.rgb.b = {4{hpos_reg[4]}};
  end

  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pat
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) pat_pipe[gi] <= '0;
          else pat_pipe[gi] <= pat_now;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) pat_pipe[gi] <= '0;
          else pat_pipe[gi] <= pat_pipe[gi-1];
        end
      end
    end
  endgenerate

  assign pat_last = pat_pipe[RD_LAT-1];
`endif

  // ---------------- pixel select and output register ----------------
  always_comb begin
    pix_next = '0;
    if (ctrl_last.in_fb && ctrl_last.show_fb) pix_next = rd_data;
    else if (ctrl_last.de) pix_next = BG;
`ifdef VGA_FB_SCANOUT_PATTERN_EN
    if (ctrl_last.de && pat_last.en) pix_next = PIX_W'(rgb444_pack(pat_last.rgb));
`endif
  end

  assign color_next = rgb444_unpack(pix_next[11:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      de          <= 1'b0;
      r           <= 4'd0;
      g           <= 4'd0;
      b           <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ctrl_last.hs ? HS_ACT : ~HS_ACT;
      vsync       <= ctrl_last.vs ? VS_ACT : ~VS_ACT;
      de          <= ctrl_last.de;
      r           <= color_next.r;
      g           <= color_next.g;
      b           <= color_next.b;
      frame_start <= ctrl_last.fs;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout using a shrunken timing so whole frames fit the run.
// With VGA_FB_SCANOUT_PATTERN_EN defined it also drives pattern_sel and models the grid.
module tb_vga_fb_scanout;

  localparam int HV = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int VV = 20, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int XB = 3, YB = 2, SH = 2;
  localparam int RD_LAT = 2;
  localparam int LAT = RD_LAT + 1;
  localparam logic [11:0] BGC = 12'h5A3;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam logic [15:0] RST_O = {~HPOL, ~VPOL, 2'b00, 12'h000};

  typedef struct {
    logic [15:0] o;
    int h;
    int v;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        fb_enable;
  logic        psel;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  r, g, b;
  logic [15:0] obs;

  exp_t        q[$];
  logic [11:0] mem [32];
  int          mh, mv;
  logic        mfb, mpat;
  int          n_total, n_bad;
  int          cyc, last_fs, de_cnt, since_rel;
  logic        hs_seen;

  vga_fb_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(1),
    .FB_XBITS(XB), .FB_YBITS(YB), .SCALE_SHIFT(SH),
    .PIX_W(12), .RD_LAT(RD_LAT), .BG(BGC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .fb_enable(fb_enable),
`ifdef VGA_FB_SCANOUT_PATTERN_EN
    .pattern_sel(psel),
`endif
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .r(r),
    .g(g),
    .b(b),
    .frame_start(frame_start)
  );

  assign obs = {hsync, vsync, de, frame_start, r, g, b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expect_px(input int h, input int v, input logic en, input logic pat);
    logic vis, infb, hsa, vsa, fs;
    logic [11:0] p;
    logic [4:0] addr;
    vis  = (h < HV) && (v < VV);
    infb = vis && ((h >> SH) < (1 << XB)) && ((v >> SH) < (1 << YB));
    addr = 5'((((v >> SH) & 3) << XB) | ((h >> SH) & 7));
    p = 12'h000;
    if (pat && vis) p = {{4{((h % 8) == 0) || ((v % 8) == 0)}}, {4{((v >> 4) & 1) == 1}}, {4{((h >> 4) & 1) == 1}}};
    else if (infb && en) p = mem[addr];
    else if (vis) p = BGC;
    hsa = (h >= HV + HFP) && (h < HV + HFP + HS);
    vsa = (v >= VV + VFP) && (v < VV + VFP + VS);
    fs  = (h == 0) && (v == 0);
    return {hsa ? HPOL : ~HPOL, vsa ? VPOL : ~VPOL, vis, fs, p};
  endfunction

  // One clock: model the current position, clock the DUT, compare the output due now
  task automatic step();
    exp_t e;
    logic en, pat;
    if (reset) begin
      q.delete();
      e.o = RST_O; e.h = -1; e.v = -1;
      repeat (RD_LAT + 1) q.push_back(e);
      mh = 0; mv = 0; mfb = 1'b0; mpat = 1'b0;
      since_rel = 0; hs_seen = 1'b0; last_fs = -1; de_cnt = 0;
    end else begin
      en  = (mh == 0 && mv == 0) ? fb_enable : mfb;
      pat = (mh == 0 && mv == 0) ? psel : mpat;
      if (mh == 0 && mv == 0) begin mfb = fb_enable; mpat = psel; end
      e.o = expect_px(mh, mv, en, pat); e.h = mh; e.v = mv;
      q.push_back(e);
      mh++;
      if (mh == HT) begin mh = 0; mv++; if (mv == VT) mv = 0; end
    end
    if (wr_en) mem[wr_addr] = wr_data;
    @(posedge clk); #1;
    cyc++;
    e = q.pop_front();
    n_total++;
    assert (obs === e.o) else begin
      n_bad++;
      $error("FAIL pix h=%0d v=%0d observed=%h expected=%h", e.h, e.v, obs, e.o);
    end
    if (!reset) begin
      since_rel++;
      if (!hs_seen && hsync === HPOL) begin
        hs_seen = 1'b1;
        n_total++;
        assert (since_rel == HV + HFP + LAT) else begin
          n_bad++;
          $error("FAIL first_hsync observed=%0d expected=%0d", since_rel, HV + HFP + LAT);
        end
      end
      if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_total++;
          assert (cyc - last_fs == FRAME) else begin
            n_bad++;
            $error("FAIL frame_period observed=%0d expected=%0d", cyc - last_fs, FRAME);
          end
          n_total++;
          assert (de_cnt - 1 == HV * VV) else begin
            n_bad++;
            $error("FAIL de_count observed=%0d expected=%0d", de_cnt - 1, HV * VV);
          end
        end
        last_fs = cyc;
        de_cnt = 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_origin();
    for (int i = 0; i < FRAME && !(mh == 0 && mv == 0); i++) step();
  endtask

  initial begin
    n_total = 0; n_bad = 0; cyc = 0; last_fs = -1; de_cnt = 0; since_rel = 0;
    hs_seen = 1'b0; mh = 0; mv = 0; mfb = 1'b0; mpat = 1'b0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; fb_enable = 1'b0; psel = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
    @(negedge clk);

    // Reset held three cycles
    run(3);
    reset = 1'b0;

    // Frame 0 shows BG while the whole framebuffer is filled
    for (int a = 0; a < 32; a++) begin
      wr_en = 1'b1;
      wr_addr = 5'(a);
      wr_data = (a == 0) ? 12'hF00 : (a == 1) ? 12'h0F0 : 12'($urandom);
      step();
    end
    wr_en = 1'b0;
    fb_enable = 1'b1;
    run_to_origin();

    // Frame 1: framebuffer on; writes collide with reads, enable drops mid-frame
    run(FRAME / 2);
    fb_enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wr_en = 1'b1;
      if ((i % 4) == 0 && mh < 32 && mv < 16) wr_addr = 5'(((mv >> SH) << XB) | (mh >> SH));
      else wr_addr = 5'($urandom_range(0, 31));
      wr_data = 12'($urandom);
      step();
    end
    wr_en = 1'b0;
    run_to_origin();

    // Frame 2: BG; re-enabling mid-frame only affects frame 3
    run(100);
    fb_enable = 1'b1;
    run_to_origin();

    // Frame 3: framebuffer again, then a single-cycle reset mid-line
    run(300);
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef VGA_FB_SCANOUT_PATTERN_EN
    psel = 1'b1;
`endif
    run(2 * FRAME + 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
